// File: rtl/spi_calc_master.sv
// spi_calc_master: SPI mode-0 master for the calculator link.
// It sends HS_REQ, 00, num1, num2, operacion, 00 in one 6-byte frame. It checks
// for HS_ACK in RX byte1 and takes the result from RX byte5[3:0].
// Optional feature macro: SPI_HS_RETRY_EN. When defined, a bad handshake is
// retried up to MAX_RETRY times, with a CLK_DIV-cycle CS gap between attempts.
module spi_calc_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [7:0]  HS_REQ    = 8'hAA,
  parameter logic [7:0]  HS_ACK    = 8'hBB,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [1:0] operacion,
  output logic       busy,
  output logic       done,
  output logic [3:0] resultado,
  output logic       hs_error,
  output logic       LED_handshake,
  output logic       CS,
  output logic       SLCK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, BYTE_END, CS_HOLD,
`ifdef SPI_HS_RETRY_EN
    RETRY_GAP,
`endif
    ERROR, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   div_reg, div_next;
  logic [2:0]      bit_reg, bit_next;
  logic            phase_reg, phase_next;   // 0: SLCK high half, 1: SLCK low half
  logic [2:0]      byte_reg, byte_next;
  logic [7:0]      rx_reg, rx_next;
  logic [3:0]      num1_reg, num1_next, num2_reg, num2_next;
  logic [1:0]      op_reg, op_next;
  logic            cs_reg, cs_next, slck_reg, slck_next, mosi_reg, mosi_next;
  logic [3:0]      res_reg, res_next;
  logic            hs_err_reg, hs_err_next, led_reg, led_next;
  logic [7:0]      tx_cur, tx_nxt;

`ifdef SPI_HS_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0]   retry_reg, retry_next;
`else
  logic            unused_max_retry;
  assign unused_max_retry = (MAX_RETRY > 0);
`endif

  // Transmit byte for a given frame position; positions past byte5 send zeros.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [3:0] a,
                                         input logic [3:0] b, input logic [1:0] op);
    case (idx)
      3'd0:    return HS_REQ;
      3'd2:    return {4'h0, a};
      3'd3:    return {4'h0, b};
      3'd4:    return {6'h0, op};
      default: return 8'h00;
    endcase
  endfunction

  assign tx_cur = tx_byte(byte_reg, num1_reg, num2_reg, op_reg);
  assign tx_nxt = tx_byte(byte_reg + 3'd1, num1_reg, num2_reg, op_reg);

  // State and datapath registers; async reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      div_reg    <= '0;
      bit_reg    <= '0;
      phase_reg  <= 1'b0;
      byte_reg   <= '0;
      rx_reg     <= '0;
      num1_reg   <= '0;
      num2_reg   <= '0;
      op_reg     <= '0;
      cs_reg     <= 1'b1;
      slck_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
      res_reg    <= '0;
      hs_err_reg <= 1'b0;
      led_reg    <= 1'b0;
`ifdef SPI_HS_RETRY_EN
      retry_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      phase_reg  <= phase_next;
      byte_reg   <= byte_next;
      rx_reg     <= rx_next;
      num1_reg   <= num1_next;
      num2_reg   <= num2_next;
      op_reg     <= op_next;
      cs_reg     <= cs_next;
      slck_reg   <= slck_next;
      mosi_reg   <= mosi_next;
      res_reg    <= res_next;
      hs_err_reg <= hs_err_next;
      led_reg    <= led_next;
`ifdef SPI_HS_RETRY_EN
      retry_reg  <= retry_next;
`endif
    end
  end

  // Next-state and pin logic. BYTE_END takes the place of the last clk of the
  // final SLCK-low half of each byte, so the SLCK period stays 2*CLK_DIV
  // across byte boundaries. A byte is therefore 16*CLK_DIV cycles long,
  // counting its BYTE_END cycle.
  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    bit_next    = bit_reg;
    phase_next  = phase_reg;
    byte_next   = byte_reg;
    rx_next     = rx_reg;
    num1_next   = num1_reg;
    num2_next   = num2_reg;
    op_next     = op_reg;
    cs_next     = cs_reg;
    slck_next   = slck_reg;
    mosi_next   = mosi_reg;
    res_next    = res_reg;
    hs_err_next = hs_err_reg;
    led_next    = led_reg;
`ifdef SPI_HS_RETRY_EN
    retry_next  = retry_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          num1_next   = num1;
          num2_next   = num2;
          op_next     = operacion;
          hs_err_next = 1'b0;
          led_next    = 1'b0;
`ifdef SPI_HS_RETRY_EN
          retry_next  = '0;
`endif
          div_next    = '0;
          bit_next    = '0;
          phase_next  = 1'b0;
          byte_next   = '0;
          cs_next     = 1'b0;
          slck_next   = 1'b0;
          mosi_next   = HS_REQ[7];
          state_next  = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          phase_next = 1'b0;
          slck_next  = 1'b1;
          rx_next    = {rx_reg[6:0], MISO};
          state_next = SHIFT;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      SHIFT: begin
        if (!phase_reg) begin
          if (div_reg == DIV_LAST) begin
            div_next   = '0;
            phase_next = 1'b1;
            slck_next  = 1'b0;
            mosi_next  = (bit_reg == 3'd7) ? tx_nxt[7] : tx_cur[3'd6 - bit_reg];
          end else begin
            div_next = div_reg + DW'(1);
          end
        end else if (bit_reg == 3'd7 && div_reg == DIV_PRE) begin
          state_next = BYTE_END;
        end else if (div_reg == DIV_LAST) begin
          div_next   = '0;
          phase_next = 1'b0;
          slck_next  = 1'b1;
          bit_next   = bit_reg + 3'd1;
          rx_next    = {rx_reg[6:0], MISO};
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      BYTE_END: begin
        div_next   = '0;
        bit_next   = '0;
        phase_next = 1'b0;
        if (byte_reg == 3'd1 && rx_reg != HS_ACK) begin
          cs_next   = 1'b1;
          mosi_next = 1'b0;
`ifdef SPI_HS_RETRY_EN
          if (retry_reg < RW'(MAX_RETRY)) begin
            retry_next = retry_reg + RW'(1);
            state_next = RETRY_GAP;
          end else begin
            hs_err_next = 1'b1;
            state_next  = ERROR;
          end
`else
          hs_err_next = 1'b1;
          state_next  = ERROR;
`endif
        end else if (byte_reg == 3'd5) begin
          res_next   = rx_reg[3:0];
          state_next = CS_HOLD;
        end else begin
          if (byte_reg == 3'd1) led_next = 1'b1;
          byte_next  = byte_reg + 3'd1;
          slck_next  = 1'b1;
          rx_next    = {rx_reg[6:0], MISO};
          state_next = SHIFT;
        end
      end
      CS_HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          cs_next    = 1'b1;
          state_next = DONE;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
`ifdef SPI_HS_RETRY_EN
      RETRY_GAP: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          byte_next  = '0;
          cs_next    = 1'b0;
          mosi_next  = HS_REQ[7];
          state_next = CS_SETUP;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
`endif
      ERROR:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state_reg != IDLE) && (state_reg != DONE);
  assign done          = (state_reg == DONE);
  assign resultado     = res_reg;
  assign hs_error      = hs_err_reg;
  assign LED_handshake = led_reg;
  assign CS            = cs_reg;
  assign SLCK          = slck_reg;
  assign MOSI          = mosi_reg;

endmodule

// File: tb/tb_spi_calc_master.sv
// Testbench for spi_calc_master (CLK_DIV=2) with a mode-0 slave model.
// It scoreboards the MOSI bytes and checks frame timing, results and flags.
// When SPI_HS_RETRY_EN is defined, the bad-ack frame is replaced by a retry frame.
module tb_spi_calc_master;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, miso;
  logic [3:0] num1, num2;
  logic [1:0] operacion;
  logic       busy, done, hs_error, led, cs, slck, mosi;
  logic [3:0] resultado;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  int         attempt, ack_on, s_bit, s_byte;
  logic [7:0] s_rx, s_tmp;
  logic [3:0] slave_res;

  spi_calc_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num1(num1), .num2(num2),
    .operacion(operacion), .busy(busy), .done(done), .resultado(resultado),
    .hs_error(hs_error), .LED_handshake(led), .CS(cs), .SLCK(slck),
    .MOSI(mosi), .MISO(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave response byte for a frame position; the ack depends on the attempt number.
  function automatic logic [7:0] sbyte(input int idx);
    if (idx == 0) return 8'h3C;
    if (idx == 1) return (attempt >= ack_on) ? 8'hBB : 8'h5A;
    if (idx == 5) return {4'hA, slave_res};
    return 8'h55;
  endfunction

  // Slave: start a new frame on CS fall.
  always @(negedge cs) begin
    attempt++;
    s_bit  = 0;
    s_byte = 0;
    s_tmp  = sbyte(0);
    miso   = s_tmp[7];
  end

  // Slave: sample MOSI on SLCK rise and score each complete byte.
  always @(posedge slck) begin
    if (cs === 1'b0) begin
      s_rx = {s_rx[6:0], mosi};
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        s_byte++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL mosi_byte: got %02h expected none", s_rx);
        end else begin
          exp_b = exp_q.pop_front();
          check("mosi_byte", 32'(s_rx), 32'(exp_b));
        end
      end
    end
  end

  // Slave: present the next MISO bit on SLCK fall.
  always @(negedge slck) begin
    if (cs === 1'b0 && s_byte < 6) begin
      s_tmp = sbyte(s_byte);
      miso  = s_tmp[7 - s_bit];
    end
  end

  task automatic push_frame(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input int n);
    logic [7:0] f[6];
    f[0] = 8'hAA; f[1] = 8'h00; f[2] = {4'h0, a}; f[3] = {4'h0, b}; f[4] = {6'h0, op}; f[5] = 8'h00;
    for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
  endtask

  // Pulse start, then watch one frame to done; optionally disturb inputs mid-frame.
  task automatic run_frame(input int poke_at, output int cycles, output int rises,
                           output int cs_low, output int cs_rises, output int bad_period);
    logic prev_slck, prev_cs, seen;
    int   last_rise;
    prev_slck = 1'b0; prev_cs = 1'b1; seen = 1'b0; last_rise = -1;
    cycles = 0; rises = 0; cs_low = 0; cs_rises = 0; bad_period = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 2000; i++) begin
      cycles++;
      if (!cs) cs_low++;
      if (cs && !prev_cs) cs_rises++;
      if (slck && !prev_slck) begin
        if (last_rise >= 0 && cycles - last_rise != 2 * CLK_DIV) bad_period++;
        rises++;
        last_rise = cycles;
      end
      prev_slck = slck;
      prev_cs   = cs;
      if (cycles == poke_at) begin
        start = 1'b1; num1 = 4'hF; num2 = 4'hF; operacion = 2'b11;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    $display("frame: cycles=%0d rises=%0d cs_low=%0d cs_rises=%0d res=%0h hs_err=%0b led=%0b",
             cycles, rises, cs_low, cs_rises, resultado, hs_error, led);
  endtask

  int cyc, rs, csl, csr, badp;
  logic hit;

  initial begin
    rst_n = 1'b0; start = 1'b0; num1 = '0; num2 = '0; operacion = '0; miso = 1'b0;
    attempt = 0; ack_on = 1; s_bit = 0; s_byte = 0; s_rx = '0; slave_res = 4'h7;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_slck", 32'(slck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(resultado), 32'd0);
    check("rst_hs_error", 32'(hs_error), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transaction: 3, 4, op 0; the slave returns 7.
    num1 = 4'd3; num2 = 4'd4; operacion = 2'd0; slave_res = 4'h7; attempt = 0; ack_on = 1;
    push_frame(num1, num2, operacion, 6);
    run_frame(-1, cyc, rs, csl, csr, badp);
    check("t1_cycles", 32'(cyc), 32'd197);
    check("t1_rises", 32'(rs), 32'd48);
    check("t1_cs_low", 32'(csl), 32'd196);
    check("t1_period", 32'(badp), 32'd0);
    check("t1_cs_rises", 32'(csr), 32'd1);
    check("t1_res", 32'(resultado), 32'h7);
    check("t1_hs_error", 32'(hs_error), 32'd0);
    check("t1_led", 32'(led), 32'd1);
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t1_done_once", 32'(done), 32'd0);

    // Operands change and start is re-pulsed mid-frame; a start during DONE is ignored.
    num1 = 4'h9; num2 = 4'hA; operacion = 2'd3; slave_res = 4'hC; attempt = 0;
    push_frame(num1, num2, operacion, 6);
    run_frame(30, cyc, rs, csl, csr, badp);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t5_start_at_done_busy", 32'(busy), 32'd0);
    check("t5_start_at_done_cs", 32'(cs), 32'd1);
    check("t5_cycles", 32'(cyc), 32'd197);
    check("t5_res", 32'(resultado), 32'hC);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

`ifdef SPI_HS_RETRY_EN
    // The slave acks only on the third attempt: two CS gaps, then success.
    num1 = 4'd1; num2 = 4'd5; operacion = 2'd1; slave_res = 4'h2; attempt = 0; ack_on = 3;
    push_frame(num1, num2, operacion, 2);
    push_frame(num1, num2, operacion, 2);
    push_frame(num1, num2, operacion, 6);
    run_frame(-1, cyc, rs, csl, csr, badp);
    check("t3_cs_rises", 32'(csr), 32'd3);
    check("t3_cycles", 32'(cyc), 32'd333);
    check("t3_cs_low", 32'(csl), 32'd328);
    check("t3_hs_error", 32'(hs_error), 32'd0);
    check("t3_res", 32'(resultado), 32'h2);
    check("t3_led", 32'(led), 32'd1);
    check("t3_queue", 32'(exp_q.size()), 32'd0);
    ack_on = 1;
    slave_res = 4'hC;
`else
    // Bad ack: CS rises after byte1, error flagged, result kept.
    num1 = 4'd5; num2 = 4'd6; operacion = 2'd2; slave_res = 4'h1; attempt = 0; ack_on = 100;
    push_frame(num1, num2, operacion, 2);
    run_frame(-1, cyc, rs, csl, csr, badp);
    check("t2_cycles", 32'(cyc), 32'd68);
    check("t2_cs_low", 32'(csl), 32'd66);
    check("t2_rises", 32'(rs), 32'd16);
    check("t2_hs_error", 32'(hs_error), 32'd1);
    check("t2_res_kept", 32'(resultado), 32'hC);
    check("t2_led", 32'(led), 32'd0);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    ack_on = 1;
`endif

    // Reset during byte3: the pins idle at once, and no done pulse follows.
    num1 = 4'd1; num2 = 4'd2; operacion = 2'd1; attempt = 0;
    push_frame(num1, num2, operacion, 6);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (s_byte == 3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reach_byte3", 32'(hit), 32'd1);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_cs", 32'(cs), 32'd1);
    check("t6_slck", 32'(slck), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_done", 32'(done), 32'd0);
    end
    check("t6_res_reset", 32'(resultado), 32'h0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame after the reset.
    num1 = 4'd2; num2 = 4'd6; operacion = 2'd2; slave_res = 4'h3; attempt = 0;
    push_frame(num1, num2, operacion, 6);
    run_frame(-1, cyc, rs, csl, csr, badp);
    check("t6_cycles", 32'(cyc), 32'd197);
    check("t6_rises", 32'(rs), 32'd48);
    check("t6_res", 32'(resultado), 32'h3);
    check("t6_hs_error", 32'(hs_error), 32'd0);
    check("t6_queue", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
